clint_mh: RTL and testbench

Multi-hart, parametrised core-local interruptor: a 64-bit `mtime` counter, one `mtimecmp` and one `msip` per hart, and a Wishbone classic slave port. It adds a programmable tick prescaler, an optional RTC-edge timebase, a timer-enable control and byte-lane writes. It sits on the peripheral Wishbone segment beside the PLIC and drives each core's `mtip`/`msip` inputs.

---
 rtl/clint_mh.sv | 194 +++++++++++++++++++
 tb/tb_clint_mh.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_mh.sv
// ============================================================================
// Module   : clint_mh
// Brief    : Multi-hart core-local interruptor (mtime/mtimecmp/msip) on a Wishbone classic slave port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clint_mh #(
    parameter int PADDR_SIZE = 30,
    parameter int PDATA_SIZE = 32,
    parameter int NR_CORES   = 4,
    parameter int PRESCALE_W = 16,
    parameter int USE_RTC    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic                  wb_we,
    input  logic [3:0]            wb_sel,
    input  logic [PADDR_SIZE-1:0] wb_adr,
    input  logic [PDATA_SIZE-1:0] wb_dat_i,
    output logic [PDATA_SIZE-1:0] wb_dat_o,
    output logic                  wb_ack,
    input  logic                  rtc_i,
    output logic [NR_CORES-1:0]   timer_irq_o,
    output logic [NR_CORES-1:0]   ipi_o,
    output logic [63:0]           mtime_o
);

    localparam logic [13:0] c_WORD_PRESCALE = 14'h2FFC;
    localparam logic [13:0] c_WORD_CTRL     = 14'h2FFD;
    localparam logic [13:0] c_WORD_MTIME_LO = 14'h2FFE;
    localparam logic [13:0] c_WORD_MTIME_HI = 14'h2FFF;
    localparam logic [11:0] c_NR_MSIP       = 12'(NR_CORES);
    localparam logic [10:0] c_NR_CMP        = 11'(NR_CORES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t                  state_q;
    logic                    ack_q;
    logic [31:0]             rdata_q;
    logic [63:0]             mtime_q;
    logic [63:0]             mtimecmp_q [NR_CORES];
    logic [NR_CORES-1:0]     msip_q;
    logic [NR_CORES-1:0]     irq_q;
    logic [PRESCALE_W-1:0]   prescale_q;
    logic                    ctrl_q;

    logic [13:0]             w_word;
    logic                    w_acc;
    logic                    w_wr;
    logic                    w_msip_sel;
    logic                    w_cmp_sel;
    logic                    w_tick;
    logic [31:0]             w_rdata;
    logic                    unused_adr;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    assign w_word     = wb_adr[13:0];
    assign unused_adr = ^wb_adr[PADDR_SIZE-1:14];
    assign w_acc      = (state_q == ST_IDLE) && wb_cyc && wb_stb;
    assign w_wr       = w_acc && wb_we;
    assign w_msip_sel = (w_word[13:12] == 2'b00) && (w_word[11:0] < c_NR_MSIP);
    assign w_cmp_sel  = (w_word[13:12] == 2'b01) && (w_word[11:1] < c_NR_CMP);

    always_comb begin
        w_rdata = '0;
        if (w_msip_sel) begin
            for (int i = 0; i < NR_CORES; i++) begin
                if (w_word[3:0] == i[3:0]) w_rdata = {31'b0, msip_q[i]};
            end
        end else if (w_cmp_sel) begin
            for (int i = 0; i < NR_CORES; i++) begin
                if (w_word[4:1] == i[3:0])
                    w_rdata = w_word[0] ? mtimecmp_q[i][63:32] : mtimecmp_q[i][31:0];
            end
        end else begin
            case (w_word)
                c_WORD_PRESCALE: w_rdata = 32'(prescale_q);
                c_WORD_CTRL:     w_rdata = {31'b0, ctrl_q};
                c_WORD_MTIME_LO: w_rdata = mtime_q[31:0];
                c_WORD_MTIME_HI: w_rdata = mtime_q[63:32];
                default:         w_rdata = '0;
            endcase
        end
    end

    generate
        if (USE_RTC != 0) begin : g_rtc
            // [0],[1] synchronise rtc_i; [2] holds the previous synchronised level for edge detect
            logic [2:0] sync_q;
            always_ff @(posedge clk) begin
                if (reset) sync_q <= '0;
                else       sync_q <= {sync_q[1:0], rtc_i};
            end
            assign w_tick = ctrl_q && sync_q[1] && !sync_q[2];
        end else begin : g_prescale
            logic [PRESCALE_W-1:0] pcnt_q;
            logic                  unused_rtc;
            assign unused_rtc = rtc_i;
            assign w_tick     = ctrl_q && (pcnt_q == prescale_q);
            always_ff @(posedge clk) begin
                if (reset)
                    pcnt_q <= '0;
                else if (!ctrl_q || w_tick || (w_wr && (w_word == c_WORD_PRESCALE)))
                    pcnt_q <= '0;
                else
                    pcnt_q <= pcnt_q + 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_acc) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                        if (!wb_we) rdata_q <= w_rdata;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q    <= '0;
            prescale_q <= '0;
            ctrl_q     <= 1'b1;
            msip_q     <= '0;
            irq_q      <= '0;
            for (int i = 0; i < NR_CORES; i++) mtimecmp_q[i] <= '1;
        end else begin
            for (int i = 0; i < NR_CORES; i++) begin
                irq_q[i] <= (mtime_q >= mtimecmp_q[i]);
                if (w_wr && w_msip_sel && wb_sel[0] && (w_word[3:0] == i[3:0]))
                    msip_q[i] <= wb_dat_i[0];
                if (w_wr && w_cmp_sel && (w_word[4:1] == i[3:0])) begin
                    if (w_word[0])
                        mtimecmp_q[i][63:32] <= f_merge(mtimecmp_q[i][63:32], wb_dat_i, wb_sel);
                    else
                        mtimecmp_q[i][31:0]  <= f_merge(mtimecmp_q[i][31:0], wb_dat_i, wb_sel);
                end
            end
            if (w_wr && (w_word == c_WORD_PRESCALE))
                prescale_q <= PRESCALE_W'(f_merge(32'(prescale_q), wb_dat_i, wb_sel));
            if (w_wr && (w_word == c_WORD_CTRL) && wb_sel[0])
                ctrl_q <= wb_dat_i[0];
            // A bus write to mtime wins over a coincident tick; that tick is lost.
            if (w_wr && (w_word == c_WORD_MTIME_LO))
                mtime_q[31:0]  <= f_merge(mtime_q[31:0], wb_dat_i, wb_sel);
            else if (w_wr && (w_word == c_WORD_MTIME_HI))
                mtime_q[63:32] <= f_merge(mtime_q[63:32], wb_dat_i, wb_sel);
            else if (w_tick)
                mtime_q <= mtime_q + 64'd1;
        end
    end

    assign wb_ack      = ack_q;
    assign wb_dat_o    = rdata_q;
    assign timer_irq_o = irq_q;
    assign ipi_o       = msip_q;
    assign mtime_o     = mtime_q;

endmodule

`default_nettype wire

// File: tb/tb_clint_mh.sv
// ============================================================================
// Module   : tb_clint_mh
// Brief    : Directed self-checking bench for clint_mh (prescaler and RTC timebase instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clint_mh;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic        rtc   = 1'b0;
    logic [3:0]  sel   = 4'h0;
    logic [29:0] adr   = '0;
    logic [31:0] dati  = '0;
    logic [31:0] dato0, dato1;
    logic        ack0, ack1;
    logic [3:0]  irq0, irq1, ipi0, ipi1;
    logic [63:0] mt0, mt1;

    int n_checks = 0;
    int n_fail   = 0;

    clint_mh #(.PADDR_SIZE(30), .PDATA_SIZE(32), .NR_CORES(4), .PRESCALE_W(16), .USE_RTC(0)) u_dut (
        .clk(clk), .reset(reset), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_sel(sel),
        .wb_adr(adr), .wb_dat_i(dati), .wb_dat_o(dato0), .wb_ack(ack0), .rtc_i(rtc),
        .timer_irq_o(irq0), .ipi_o(ipi0), .mtime_o(mt0)
    );

    clint_mh #(.PADDR_SIZE(30), .PDATA_SIZE(32), .NR_CORES(4), .PRESCALE_W(16), .USE_RTC(1)) u_dut_rtc (
        .clk(clk), .reset(reset), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_sel(sel),
        .wb_adr(adr), .wb_dat_i(dati), .wb_dat_o(dato1), .wb_ack(ack1), .rtc_i(rtc),
        .timer_irq_o(irq1), .ipi_o(ipi1), .mtime_o(mt1)
    );

    // Accepted at edge A, returns exactly at edge A+1 (the ack edge).
    task automatic bus_access(input logic write, input logic [15:0] boff, input logic [31:0] data,
                              input logic [3:0] bsel, output logic [31:0] rdat);
        int waited;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = write; adr = {16'b0, boff[15:2]}; dati = data; sel = bsel;
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (ack0 !== 1'b1 && waited < 4);
        n_checks++;
        if (ack0 !== 1'b1) begin
            n_fail++;
            $display("FAIL bus_ack off=%h: ack=%b after %0d cycles, required 1", boff, ack0, waited);
        end
        rdat = dato0;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk);
    endtask

    task automatic wr(input logic [15:0] boff, input logic [31:0] data, input logic [3:0] bsel);
        logic [31:0] dummy;
        bus_access(1'b1, boff, data, bsel, dummy);
    endtask

    task automatic rd(input logic [15:0] boff, output logic [31:0] rdat);
        bus_access(1'b0, boff, 32'h0, 4'hF, rdat);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ack0 !== 1'b0 || dato0 !== 32'h0) begin
            n_fail++; $display("FAIL reset_bus: ack=%b dat=%h, required 0/00000000", ack0, dato0);
        end
        n_checks++;
        if (irq0 !== 4'h0 || ipi0 !== 4'h0 || mt0 !== 64'h0) begin
            n_fail++; $display("FAIL reset_out: irq=%h ipi=%h mtime=%h, required 0", irq0, ipi0, mt0);
        end
        // request is already pending when reset drops, so it is accepted on the very first edge
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 30'h2FFE; sel = 4'hF;
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ack0 !== 1'b1 || dato0 !== 32'h0) begin
            n_fail++; $display("FAIL reset_mtime_read: ack=%b dat=%h, required 1/00000000", ack0, dato0);
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ack0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_ack_width: ack=%b in second cycle, required 0", ack0);
        end
        rd(16'h4000, d);
        n_checks++;
        if (d !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL reset_mtimecmp: got %h, required ffffffff", d);
        end
        #1;
        n_checks++;
        if (irq0 !== 4'h0) begin
            n_fail++; $display("FAIL reset_irq: got %b, required 0000", irq0);
        end
    endtask

    task automatic test_prescale();
        wr(16'hBFF4, 32'h0, 4'hF);
        wr(16'hBFF8, 32'h0, 4'hF);
        wr(16'hBFFC, 32'h0, 4'hF);
        wr(16'hBFF0, 32'h3, 4'hF);
        wr(16'hBFF4, 32'h1, 4'hF);          // enabled at edge A, now at A+1
        repeat (2) @(posedge clk); #1;      // A+3
        n_checks++;
        if (mt0 !== 64'd0) begin n_fail++; $display("FAIL prescale_t3: mtime=%h, required 0", mt0); end
        @(posedge clk); #1;                 // A+4
        n_checks++;
        if (mt0 !== 64'd1) begin n_fail++; $display("FAIL prescale_t4: mtime=%h, required 1", mt0); end
        repeat (4) @(posedge clk); #1;      // A+8
        n_checks++;
        if (mt0 !== 64'd2) begin n_fail++; $display("FAIL prescale_t8: mtime=%h, required 2", mt0); end

        wr(16'hBFF4, 32'h0, 4'hF);
        wr(16'hBFF8, 32'hFFFF_FFFE, 4'hF);
        wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        wr(16'hBFF4, 32'h1, 4'hF);          // edge B, now at B+1
        repeat (3) @(posedge clk); #1;      // B+4
        n_checks++;
        if (mt0 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++; $display("FAIL wrap_max: mtime=%h, required ffffffffffffffff", mt0);
        end
        repeat (4) @(posedge clk); #1;      // B+8
        n_checks++;
        if (mt0 !== 64'h0) begin n_fail++; $display("FAIL wrap_zero: mtime=%h, required 0", mt0); end
        repeat (4) @(posedge clk); #1;      // B+12
        n_checks++;
        if (mt0 !== 64'h1) begin n_fail++; $display("FAIL wrap_one: mtime=%h, required 1", mt0); end
    endtask

    task automatic test_timer_cmp();
        wr(16'hBFF4, 32'h0, 4'hF);
        wr(16'hBFF0, 32'h0, 4'hF);
        wr(16'hBFF8, 32'h10, 4'hF);
        wr(16'hBFFC, 32'h0, 4'hF);
        wr(16'h4010, 32'h20, 4'hF);
        wr(16'h4014, 32'h0, 4'hF);
        wr(16'hBFF4, 32'h1, 4'hF);          // edge C, mtime = 0x10 + k after C+k
        repeat (15) @(posedge clk); #1;     // C+16
        n_checks++;
        if (mt0 !== 64'h20 || irq0 !== 4'b0000) begin
            n_fail++; $display("FAIL cmp_before: mtime=%h irq=%b, required 20/0000", mt0, irq0);
        end
        @(posedge clk); #1;                 // C+17
        n_checks++;
        if (irq0 !== 4'b0100) begin
            n_fail++; $display("FAIL cmp_hit: irq=%b, required 0100", irq0);
        end
        wr(16'h4010, 32'hFFFF_FFFF, 4'hF);
        #1;
        n_checks++;
        if (irq0 !== 4'b0000) begin
            n_fail++; $display("FAIL cmp_clear: irq=%b, required 0000", irq0);
        end
    endtask

    task automatic test_msip();
        logic [31:0] d;
        wr(16'h000C, 32'h1, 4'hF); #1;
        n_checks++;
        if (ipi0 !== 4'b1000) begin n_fail++; $display("FAIL msip3_set: ipi=%b, required 1000", ipi0); end
        wr(16'h0000, 32'h1, 4'b0010); #1;
        n_checks++;
        if (ipi0 !== 4'b1000) begin n_fail++; $display("FAIL msip0_lane: ipi=%b, required 1000", ipi0); end
        wr(16'h0000, 32'h1, 4'b0001); #1;
        n_checks++;
        if (ipi0 !== 4'b1001) begin n_fail++; $display("FAIL msip0_set: ipi=%b, required 1001", ipi0); end
        rd(16'h000C, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL msip3_read: got %h, required 00000001", d); end
        wr(16'h0010, 32'h1, 4'hF);
        rd(16'h0010, d); #1;
        n_checks++;
        if (d !== 32'h0 || ipi0 !== 4'b1001) begin
            n_fail++; $display("FAIL msip_oob: read=%h ipi=%b, required 0/1001", d, ipi0);
        end
        rd(16'h4020, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL cmp_oob: got %h, required 00000000", d); end
    endtask

    task automatic test_mtime_write();
        logic [31:0] d;
        wr(16'hBFF4, 32'h0, 4'hF);
        wr(16'hBFF0, 32'h0, 4'hF);
        wr(16'hBFFC, 32'h1234_5678, 4'hF);
        wr(16'hBFF8, 32'h0, 4'hF);
        wr(16'hBFF4, 32'h1, 4'hF);
        wr(16'hBFF8, 32'h100, 4'hF);        // edge F is a tick cycle: 0x100, then 0x101 at F+1
        wr(16'hBFF4, 32'h0, 4'hF);          // edge F+2 still ticks: 0x102, then frozen
        #1;
        n_checks++;
        if (mt0 !== 64'h1234_5678_0000_0102) begin
            n_fail++; $display("FAIL mtime_tick_write: mtime=%h, required 1234567800000102", mt0);
        end
        rd(16'hBFF8, d);
        n_checks++;
        if (d !== 32'h102) begin n_fail++; $display("FAIL mtime_lo_read: got %h, required 00000102", d); end
        wr(16'hBFFC, 32'h00CD_0000, 4'b0100);
        rd(16'hBFFC, d);
        n_checks++;
        if (d !== 32'h12CD_5678) begin n_fail++; $display("FAIL mtime_hi_lane: got %h, required 12cd5678", d); end
        wr(16'hBFF0, 32'hFFFF_FFFF, 4'hF);
        rd(16'hBFF0, d);
        n_checks++;
        if (d !== 32'h0000_FFFF) begin n_fail++; $display("FAIL prescale_width: got %h, required 0000ffff", d); end
        wr(16'hBFF0, 32'h0, 4'hF);
        rd(16'h8000, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h, required 00000000", d); end
    endtask

    task automatic test_back_to_back();
        logic exp_ack;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 30'h2FFF; sel = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            exp_ack = (k % 2 == 0);
            n_checks++;
            if (ack0 !== exp_ack || (exp_ack && dato0 !== 32'h12CD_5678)) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: ack=%b dat=%h, required %b/12cd5678", k, ack0, dato0, exp_ack);
            end
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_rtc();
        wr(16'hBFF4, 32'h0, 4'hF);
        wr(16'hBFF8, 32'h0, 4'hF);
        wr(16'hBFFC, 32'h0, 4'hF);
        wr(16'hBFF4, 32'h1, 4'hF);
        @(negedge clk);
        rtc = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_checks++;
        if (mt1 !== 64'd0) begin n_fail++; $display("FAIL rtc_latency_early: mtime=%h, required 0", mt1); end
        @(posedge clk); #1;
        n_checks++;
        if (mt1 !== 64'd1) begin n_fail++; $display("FAIL rtc_latency: mtime=%h, required 1", mt1); end
        @(negedge clk);
        rtc = 1'b0;
        repeat (4) @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            rtc = 1'b1;
            repeat (4) @(negedge clk);
            rtc = 1'b0;
            repeat (4) @(negedge clk);
        end
        n_checks++;
        if (mt1 !== 64'd5) begin n_fail++; $display("FAIL rtc_count: mtime=%h, required 5", mt1); end
        wr(16'hBFF4, 32'h0, 4'hF);
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            rtc = 1'b1;
            repeat (4) @(negedge clk);
            rtc = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (mt1 !== 64'd5) begin n_fail++; $display("FAIL rtc_disabled: mtime=%h, required 5", mt1); end
    endtask

    initial begin
        test_reset();
        test_prescale();
        test_timer_cmp();
        test_msip();
        test_mtime_write();
        test_back_to_back();
        test_rtc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
